jk_reg_bank: RTL

- Parametrised, multi-mode successor to the single-bit JK flip-flop.
- WIDTH independent storage bits, each with its own j/k inputs, sharing one clock.
- A runtime mode select reinterprets the j/k inputs as JK, D, T or SR controls.
- Adds enable, synchronous set/clear, an illegal-SR error flag, a change strobe and a saturating activity counter.
- Used as a generic state-bit bank in later sequential projects.

---
 rtl/jk_reg_bank.sv | 139 +++++++++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a bank of WIDTH independent storage bits sharing one clock.
// A runtime mode select makes the per-bit j/k inputs act as JK, D, T or SR
// controls. The bank also provides:
//   - an update enable
//   - synchronous set and clear
//   - a sticky illegal-SR error flag
//   - a registered change strobe
//   - a saturating count of the edges at which q changed
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset (overrides everything)
//   i_en       update enable; q holds when low (set/clr still act)
//   i_mode     00 JK, 01 D, 10 T, 11 SR
//   i_j        per-bit J / D / T / S
//   i_k        per-bit K / unused / unused / R
//   i_set      synchronous load of all ones
//   i_clr      synchronous load of RESET_VAL (priority over i_set)
//   o_q        registered state
//   o_qbar     ~o_q
//   o_changed  high for the cycle after an edge at which q changed
//   o_sr_err   sticky: SR mode saw s=r=1 on some bit; cleared only by reset
//   o_act_cnt  number of edges at which q changed, saturating
module jk_reg_bank #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic             i_set,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic             o_changed,
  output logic             o_sr_err,
  output logic [CNT_W-1:0] o_act_cnt
);

  typedef enum logic [1:0] {
    ModeJk = 2'b00,
    ModeD  = 2'b01,
    ModeT  = 2'b10,
    ModeSr = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_act_cnt;

  logic [WIDTH-1:0] w_mode_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_sr_illegal_bits;
  logic             w_sr_illegal;
  logic             w_changed;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  // Per-bit next value for an enabled, non-set/clr edge.
  always_comb begin
    w_mode_next       = r_q;
    w_sr_illegal_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (w_mode)
        ModeJk: begin
          unique case ({i_j[i], i_k[i]})
            2'b00:   w_mode_next[i] = r_q[i];
            2'b01:   w_mode_next[i] = 1'b0;
            2'b10:   w_mode_next[i] = 1'b1;
            default: w_mode_next[i] = ~r_q[i];
          endcase
        end
        ModeD: w_mode_next[i] = i_j[i];
        ModeT: w_mode_next[i] = i_j[i] ? ~r_q[i] : r_q[i];
        default: begin
          unique case ({i_j[i], i_k[i]})
            2'b10:   w_mode_next[i] = 1'b1;
            2'b01:   w_mode_next[i] = 1'b0;
            2'b00:   w_mode_next[i] = r_q[i];
            default: begin
              // s=r=1: the bit holds and the error is flagged.
              w_mode_next[i]       = r_q[i];
              w_sr_illegal_bits[i] = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  // Source priority: clr > set > en.
  always_comb begin
    w_q_next     = r_q;
    w_sr_illegal = 1'b0;
    if (i_clr) begin
      w_q_next = RESET_VAL;
    end else if (i_set) begin
      w_q_next = '1;
    end else if (i_en) begin
      w_q_next     = w_mode_next;
      w_sr_illegal = (w_mode == ModeSr) && (|w_sr_illegal_bits);
    end
  end

  assign w_changed = (w_q_next != r_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q       <= RESET_VAL;
      r_changed <= 1'b0;
      r_sr_err  <= 1'b0;
      r_act_cnt <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_changed;
      if (w_sr_illegal) begin
        r_sr_err <= 1'b1;
      end
      if (w_changed && (r_act_cnt != CntMax)) begin
        r_act_cnt <= r_act_cnt + 1'b1;
      end
    end
  end

  assign o_q       = r_q;
  assign o_qbar    = ~r_q;
  assign o_changed = r_changed;
  assign o_sr_err  = r_sr_err;
  assign o_act_cnt = r_act_cnt;

endmodule
